// File: rtl/metro_pkg.sv
// Shared definitions for the metro card kiosks: controller state encoding,
// display codes and default balance sizing.
package metro_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CARD,
      READ,
      ACCEPT,
      WRITE,
      DONE,
      ERROR
   } state_t;

   localparam logic [2:0] DISP_BLANK = 3'b000;
   localparam logic [2:0] DISP_WAIT  = 3'b111;

   localparam int DEF_BAL_W   = 3;
   localparam int DEF_MAX_BAL = 7;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/metro_sat_adder.sv
// Combinational balance check: sums balance, credit and coin with two guard
// bits and flags a total above the card's maximum storable balance.
module metro_sat_adder
   import metro_pkg::*;
#(
   parameter int BAL_W   = DEF_BAL_W,
   parameter int MAX_BAL = DEF_MAX_BAL
) (
   input  logic [BAL_W-1:0] bal,
   input  logic [BAL_W-1:0] credit,
   input  logic [BAL_W-1:0] coin,
   output logic [BAL_W-1:0] sum,
   output logic             ovf
);

   logic [BAL_W+1:0] wide;

   always_comb begin
      wide = {2'b00, bal} + {2'b00, credit} + {2'b00, coin};
      ovf  = (wide > (BAL_W+2)'(MAX_BAL));
      sum  = wide[BAL_W-1:0];
   end

endmodule

// File: rtl/metro_topup.sv
// Top-up kiosk controller: reads the card balance, collects coins as credit
// and writes the new balance back over a req/ack handshake.
module metro_topup
   import metro_pkg::*;
#(
   parameter int BAL_W       = DEF_BAL_W,
   parameter int MAX_BAL     = DEF_MAX_BAL,
   parameter int READ_CYCLES = 2,
   parameter int ACK_TIMEOUT = 8,
   parameter int SHOW_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             card_inserted,
   input  logic [BAL_W-1:0] card_balance,
   input  logic             coin_valid,
   input  logic [BAL_W-1:0] coin_value,
   input  logic             confirm,
   input  logic             cancel,
   output logic             wr_en,
   output logic [BAL_W-1:0] wr_data,
   input  logic             wr_ack,
   output logic             coin_reject,
   output logic             refund_valid,
   output logic [BAL_W-1:0] refund_amt,
   output logic [BAL_W-1:0] out,
   output logic             err
);

   localparam int CNT_MAX = max3(READ_CYCLES, ACK_TIMEOUT, SHOW_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [BAL_W-1:0] credit, credit_next;
   logic [BAL_W-1:0] bal_r, bal_next;
   logic             wr_en_next;
   logic [BAL_W-1:0] wr_data_next;
   logic             coin_reject_next;
   logic             refund_valid_next;
   logic [BAL_W-1:0] refund_amt_next;

   logic [BAL_W-1:0] coin_add;
   logic [BAL_W-1:0] total;
   logic             over;

   // With no coin this cycle the adder output is bal_r+credit, which is the
   // value committed on confirm (confirm is only honoured without a coin).
   assign coin_add = coin_valid ? coin_value : '0;

   metro_sat_adder #(
      .BAL_W   (BAL_W),
      .MAX_BAL (MAX_BAL)
   ) u_sat_adder (
      .bal    (bal_r),
      .credit (credit),
      .coin   (coin_add),
      .sum    (total),
      .ovf    (over)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         credit       <= '0;
         bal_r        <= '0;
         wr_en        <= 1'b0;
         wr_data      <= '0;
         coin_reject  <= 1'b0;
         refund_valid <= 1'b0;
         refund_amt   <= '0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         credit       <= credit_next;
         bal_r        <= bal_next;
         wr_en        <= wr_en_next;
         wr_data      <= wr_data_next;
         coin_reject  <= coin_reject_next;
         refund_valid <= refund_valid_next;
         refund_amt   <= refund_amt_next;
      end
   end

   always_comb begin
      state_next        = state;
      cnt_next          = cnt;
      credit_next       = credit;
      bal_next          = bal_r;
      wr_en_next        = wr_en;
      wr_data_next      = wr_data;
      coin_reject_next  = 1'b0;
      refund_valid_next = 1'b0;
      refund_amt_next   = '0;
      out               = BAL_W'(DISP_BLANK);
      err               = 1'b0;

      case (state)
         IDLE: begin
            state_next = WAIT_CARD;
         end
         WAIT_CARD: begin
            out         = BAL_W'(DISP_WAIT);
            cnt_next    = '0;
            credit_next = '0;
            if (card_inserted) state_next = READ;
         end
         READ: begin
            if (!card_inserted) begin
               state_next = WAIT_CARD;
            end else if (cnt == CNT_W'(READ_CYCLES - 1)) begin
               bal_next   = card_balance;
               cnt_next   = '0;
               state_next = ACCEPT;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ACCEPT: begin
            out = bal_r + credit;
            // Card removal is treated as a cancel so the customer gets the coins back.
            if (cancel || !card_inserted) begin
               refund_valid_next = 1'b1;
               refund_amt_next   = credit;
               state_next        = WAIT_CARD;
            end else if (coin_valid) begin
               if (over) coin_reject_next = 1'b1;
               else      credit_next      = credit + coin_value;
            end else if (confirm) begin
               if (credit == '0) begin
                  state_next = WAIT_CARD;
               end else begin
                  wr_data_next = total;
                  wr_en_next   = 1'b1;
                  cnt_next     = '0;
                  state_next   = WRITE;
               end
            end
         end
         WRITE: begin
            if (wr_ack) begin
               wr_en_next = 1'b0;
               cnt_next   = '0;
               state_next = DONE;
            end else if (!card_inserted || cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               wr_en_next        = 1'b0;
               refund_valid_next = 1'b1;
               refund_amt_next   = credit;
               cnt_next          = '0;
               state_next        = ERROR;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         DONE, ERROR: begin
            if (state == DONE) out = wr_data;
            else               err = 1'b1;
            if (cnt == CNT_W'(SHOW_CYCLES - 1)) begin
               cnt_next   = '0;
               state_next = WAIT_CARD;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_metro_topup.sv
// Scoreboard bench for metro_topup: directed scenarios followed by random
// kiosk sessions, checked against an arithmetic model of balance and credit.
module tb_metro_topup;

   localparam int MAX_BAL = 7;
   localparam int EV_REJECT = 0;
   localparam int EV_REFUND = 1;
   localparam int EV_WRITE  = 2;

   logic       clk, reset;
   logic       card_inserted, coin_valid, confirm, cancel, wr_ack;
   logic [2:0] card_balance, coin_value;
   logic       wr_en, coin_reject, refund_valid, err;
   logic [2:0] wr_data, refund_amt, out;

   typedef struct { int kind; int val; } ev_t;
   ev_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int bal, credit;

   metro_topup dut (
      .clk(clk), .reset(reset), .card_inserted(card_inserted),
      .card_balance(card_balance), .coin_valid(coin_valid),
      .coin_value(coin_value), .confirm(confirm), .cancel(cancel),
      .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack),
      .coin_reject(coin_reject), .refund_valid(refund_valid),
      .refund_amt(refund_amt), .out(out), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input int kind, input int val);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event kind=%0d actual=%0d expected=none", kind, val);
      end else begin
         ev_t e;
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_value", val, e.val);
      end
   endtask

   // Monitor: every pulse or write request the DUT presents is matched in order.
   initial begin
      logic wr_prev;
      wr_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (coin_reject)         pop_cmp(EV_REJECT, 0);
         if (refund_valid)        pop_cmp(EV_REFUND, int'(refund_amt));
         if (wr_en && !wr_prev)   pop_cmp(EV_WRITE, int'(wr_data));
         wr_prev = wr_en;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session(input int b);
      chk("wait_disp", int'(out), 7);
      card_balance  = 3'(b);
      card_inserted = 1'b1;
      bal    = b;
      credit = 0;
      tick();
      chk("read_disp", int'(out), 0);
      tick();
      tick();
      chk("balance_disp", int'(out), b);
   endtask

   task automatic do_coin(input int v, input bit with_confirm);
      coin_valid = 1'b1;
      coin_value = 3'(v);
      confirm    = with_confirm;
      if (bal + credit + v <= MAX_BAL) credit += v;
      else exp_q.push_back('{EV_REJECT, 0});
      tick();
      coin_valid = 1'b0;
      confirm    = 1'b0;
      chk("accept_disp", int'(out), bal + credit);
      chk("no_write_on_coin", int'(wr_en), 0);
   endtask

   task automatic do_cancel(input bit via_removal, input bit with_confirm);
      if (via_removal) card_inserted = 1'b0;
      else             cancel = 1'b1;
      confirm = with_confirm;
      exp_q.push_back('{EV_REFUND, credit});
      tick();
      cancel = 1'b0;
      confirm = 1'b0;
      card_inserted = 1'b0;
      chk("cancel_wait_disp", int'(out), 7);
      chk("cancel_no_write", int'(wr_en), 0);
   endtask

   task automatic error_phase();
      int m;
      m = 0;
      while (err && m < 20) begin
         chk("error_disp", int'(out), 0);
         m++;
         tick();
      end
      chk("err_cycles", m, 4);
      chk("after_error_disp", int'(out), 7);
   endtask

   // mode 0: ack after d cycles; mode 1: no ack (timeout); mode 2: card pulled after d cycles
   task automatic do_confirm(input int mode, input int d, input bit pull_with_ack);
      int n;
      confirm = 1'b1;
      if (credit > 0) exp_q.push_back('{EV_WRITE, bal + credit});
      tick();
      confirm = 1'b0;
      if (credit == 0) begin
         card_inserted = 1'b0;
         chk("zero_confirm_no_write", int'(wr_en), 0);
         chk("zero_confirm_disp", int'(out), 7);
         return;
      end
      chk("wr_en_rise", int'(wr_en), 1);
      chk("wr_data", int'(wr_data), bal + credit);
      if (mode == 0) begin
         repeat (d - 1) begin
            chk("wr_en_held", int'(wr_en), 1);
            tick();
         end
         wr_ack = 1'b1;
         if (pull_with_ack) card_inserted = 1'b0;
         tick();
         wr_ack = 1'b0;
         card_inserted = 1'b0;
         chk("wr_en_drop_ack", int'(wr_en), 0);
         for (int i = 0; i < 4; i++) begin
            chk("done_disp", int'(out), bal + credit);
            chk("done_err", int'(err), 0);
            tick();
         end
         chk("after_done_disp", int'(out), 7);
      end else if (mode == 1) begin
         exp_q.push_back('{EV_REFUND, credit});
         n = 0;
         while (wr_en && n < 20) begin
            n++;
            tick();
         end
         chk("wr_en_cycles", n, 8);
         card_inserted = 1'b0;
         error_phase();
      end else begin
         repeat (d - 1) tick();
         card_inserted = 1'b0;
         exp_q.push_back('{EV_REFUND, credit});
         tick();
         chk("wr_en_drop_pull", int'(wr_en), 0);
         error_phase();
      end
   endtask

   initial begin
      int r, nc;
      reset = 1'b1;
      card_inserted = 1'b0; card_balance = '0;
      coin_valid = 1'b0; coin_value = '0;
      confirm = 1'b0; cancel = 1'b0; wr_ack = 1'b0;
      #12;
      chk("reset_wr_en", int'(wr_en), 0);
      chk("reset_out", int'(out), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_reject", int'(coin_reject), 0);
      chk("reset_refund", int'(refund_valid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("idle_disp", int'(out), 0);
      tick();

      // Basic top-up
      start_session(2);
      do_coin(1, 1'b0);
      do_coin(2, 1'b0);
      do_confirm(0, 3, 1'b0);

      // Overflow reject, then exact fill to the maximum
      start_session(6);
      do_coin(2, 1'b0);
      do_coin(1, 1'b0);
      chk("full_disp", int'(out), 7);
      do_cancel(1'b0, 1'b0);

      // Cancel with refund
      start_session(1);
      do_coin(2, 1'b0);
      do_coin(1, 1'b0);
      do_cancel(1'b0, 1'b0);

      // Ack timeout
      start_session(0);
      do_coin(4, 1'b0);
      do_confirm(1, 0, 1'b0);

      // Coincident coin+confirm, then cancel+confirm
      start_session(1);
      do_coin(2, 1'b1);
      do_cancel(1'b0, 1'b1);

      // Async reset while the write request is outstanding
      start_session(3);
      do_coin(1, 1'b0);
      confirm = 1'b1;
      exp_q.push_back('{EV_WRITE, 4});
      tick();
      confirm = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      card_inserted = 1'b0;
      #1;
      chk("async_reset_wr_en", int'(wr_en), 0);
      chk("async_reset_out", int'(out), 0);
      chk("async_reset_err", int'(err), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("post_reset_idle", int'(out), 0);
      tick();

      // Random sessions
      for (int s = 0; s < 60; s++) begin
         start_session($urandom_range(0, 7));
         nc = $urandom_range(0, 4);
         for (int c = 0; c < nc; c++)
            do_coin($urandom_range(0, 4), ($urandom_range(0, 4) == 0));
         r = $urandom_range(0, 5);
         case (r)
            0: do_cancel(1'b0, 1'b0);
            1: do_cancel(1'b1, 1'b0);
            2: do_cancel(1'b0, 1'b1);
            default: do_confirm($urandom_range(0, 2), $urandom_range(1, 8),
                                ($urandom_range(0, 1) == 1));
         endcase
      end

      repeat (3) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
